// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline control logic.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_REFILL,
        I_REFILL
    } refill_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // True when the load in E writes a register the instruction in D reads.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage OTTER pipeline: load-use, branch
// flush and cache-miss handling with a single shared refill port.
module pipeline_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rd_E,
    input  logic             memRead2_E,
    input  logic             pc_src_E,
    input  logic             imem_miss,
    input  logic             dmem_miss,
    input  logic             refill_done,
    output logic             refill_req,
    output logic             refill_sel,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [CNT_W-1:0] stall_cycles
);

    refill_state_t state;
    refill_state_t state_next;
    logic          lu;
    logic          br;

    assign lu = load_use(memRead2_E, rd_E, rs1_addr_D, rs2_addr_D);
    assign br = pc_src_E;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A D refill hands straight over to a pending I refill unless E holds
    // a taken branch, in which case the fetch is wrong-path anyway.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dmem_miss) begin
                    state_next = D_REFILL;
                end else if (!br && imem_miss) begin
                    state_next = I_REFILL;
                end
            end
            D_REFILL: begin
                if (refill_done) begin
                    state_next = (imem_miss && !br) ? I_REFILL : IDLE;
                end
            end
            I_REFILL: begin
                if (refill_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Flushes are never raised during a refill: they override stalls in the
    // pipeline registers and would destroy the held instructions.
    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        refill_req = 1'b0;
        refill_sel = 1'b0;
        if (RST) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_miss || (!br && imem_miss)) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        stall_E = 1'b1;
                        stall_M = 1'b1;
                    end else if (br) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (lu) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end
                end
                D_REFILL, I_REFILL: begin
                    stall_F    = 1'b1;
                    stall_D    = 1'b1;
                    stall_E    = 1'b1;
                    stall_M    = 1'b1;
                    refill_req = 1'b1;
                    refill_sel = (state == D_REFILL);
                end
                default: begin
                    stall_F = 1'b0;
                end
            endcase
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (stall_F && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios
// plus random traffic against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] rs1_addr_D = '0;
    logic [4:0] rs2_addr_D = '0;
    logic [4:0] rd_E = '0;
    logic       memRead2_E = 1'b0;
    logic       pc_src_E = 1'b0;
    logic       imem_miss = 1'b0;
    logic       dmem_miss = 1'b0;
    logic       refill_done = 1'b0;

    logic        req_a, sel_a, sf_a, sd_a, se_a, sm_a, fd_a, fe_a;
    logic [3:0]  sc_a;
    logic        req_b, sel_b, sf_b, sd_b, se_b, sm_b, fd_b, fe_b;
    logic [31:0] sc_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a refill is outstanding, which cache, and stall counts.
    bit      m_busy = 1'b0;
    bit      m_dcache = 1'b0;
    int      m_cnt4 = 0;
    longint  m_cnt32 = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_a (
        .CLK(CLK), .RST(RST), .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rd_E(rd_E), .memRead2_E(memRead2_E), .pc_src_E(pc_src_E),
        .imem_miss(imem_miss), .dmem_miss(dmem_miss), .refill_done(refill_done),
        .refill_req(req_a), .refill_sel(sel_a), .stall_F(sf_a), .stall_D(sd_a),
        .stall_E(se_a), .stall_M(sm_a), .flush_D(fd_a), .flush_E(fe_a),
        .stall_cycles(sc_a)
    );

    pipeline_hazard_ctrl dut_b (
        .CLK(CLK), .RST(RST), .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rd_E(rd_E), .memRead2_E(memRead2_E), .pc_src_E(pc_src_E),
        .imem_miss(imem_miss), .dmem_miss(dmem_miss), .refill_done(refill_done),
        .refill_req(req_b), .refill_sel(sel_b), .stall_F(sf_b), .stall_D(sd_b),
        .stall_E(se_b), .stall_M(sm_b), .flush_D(fd_b), .flush_E(fe_b),
        .stall_cycles(sc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model to what the next cycle should look like.
    task automatic cycle(input bit rst, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input bit mr, input bit br,
                         input bit im, input bit dm, input bit done);
        bit lu;
        bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_req, e_sel;
        @(posedge CLK);
        #1;
        RST = rst; rs1_addr_D = r1; rs2_addr_D = r2; rd_E = rd;
        memRead2_E = mr; pc_src_E = br; imem_miss = im; dmem_miss = dm;
        refill_done = done;
        #2;
        lu = mr && (rd != 0) && (rd == r1 || rd == r2);
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_req, e_sel} = '0;
        if (rst) begin
            e_fd = 1; e_fe = 1;
        end else if (m_busy) begin
            {e_sf, e_sd, e_se, e_sm} = 4'hf;
            e_req = 1; e_sel = m_dcache;
        end else if (dm || (im && !br)) begin
            {e_sf, e_sd, e_se, e_sm} = 4'hf;
        end else if (br) begin
            e_fd = 1; e_fe = 1;
        end else if (lu) begin
            e_sf = 1; e_sd = 1; e_fe = 1;
        end
        check("stall_F", 32'(sf_a), 32'(e_sf));
        check("stall_D", 32'(sd_a), 32'(e_sd));
        check("stall_E", 32'(se_a), 32'(e_se));
        check("stall_M", 32'(sm_a), 32'(e_sm));
        check("flush_D", 32'(fd_a), 32'(e_fd));
        check("flush_E", 32'(fe_a), 32'(e_fe));
        check("refill_req", 32'(req_a), 32'(e_req));
        if (e_req) check("refill_sel", 32'(sel_a), 32'(e_sel));
        check("stall_cycles4", 32'(sc_a), 32'(m_cnt4));
        check("stall_cycles32", sc_b, 32'(m_cnt32));
        check("dut_b_stall_F", 32'(sf_b), 32'(e_sf));
        if (rst) begin
            m_busy = 0; m_cnt4 = 0; m_cnt32 = 0;
        end else begin
            if (e_sf) begin
                if (m_cnt4 < 15) m_cnt4++;
                if (m_cnt32 < 64'hffff_ffff) m_cnt32++;
            end
            if (m_busy) begin
                if (done) begin
                    if (m_dcache && im && !br) m_dcache = 0;
                    else m_busy = 0;
                end
            end else if (dm) begin
                m_busy = 1; m_dcache = 1;
            end else if (im && !br) begin
                m_busy = 1; m_dcache = 0;
            end
        end
    endtask

    task automatic idle_cycle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        check("reset_flush_D", 32'(fd_a), 32'd1);
        check("reset_stall_F", 32'(sf_a), 32'd0);
        idle_cycle();
        check("reset_count", 32'(sc_a), 32'd0);

        // Load-use, then the same with rd = x0.
        cycle(0, 5, 0, 5, 1, 0, 0, 0, 0);
        check("lu_stall_F", 32'(sf_a), 32'd1);
        check("lu_flush_E", 32'(fe_a), 32'd1);
        check("lu_stall_E", 32'(se_a), 32'd0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("lu_x0_stall_F", 32'(sf_a), 32'd0);
        check("lu_x0_flush_E", 32'(fe_a), 32'd0);

        // Branch beats load-use and I-miss.
        do_reset();
        cycle(0, 7, 7, 7, 1, 1, 1, 0, 0);
        check("br_flush_D", 32'(fd_a), 32'd1);
        check("br_stall_F", 32'(sf_a), 32'd0);
        idle_cycle();
        check("br_no_refill", 32'(req_a), 32'd0);

        // D miss at t, refill_done at t+4.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("dm_req_t", 32'(req_a), 32'd0);
        check("dm_stall_t", 32'(sm_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
            check("dm_req", 32'(req_a), 32'd1);
            check("dm_sel", 32'(sel_a), 32'd1);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("dm_stall_u", 32'(sf_a), 32'd1);
        idle_cycle();
        check("dm_stall_after", 32'(sf_a), 32'd0);
        check("dm_count", 32'(sc_b), 32'd5);

        // Chained D then I refill.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
        check("chain_sel_d", 32'(sel_a), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("chain_req", 32'(req_a), 32'd1);
        check("chain_sel_i", 32'(sel_a), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle_cycle();
        check("chain_idle", 32'(req_a), 32'd0);

        // Reset in the middle of an I refill.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        check("rst_mid_req_before", 32'(req_a), 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("rst_mid_flush_D", 32'(fd_a), 32'd1);
        check("rst_mid_flush_E", 32'(fe_a), 32'd1);
        idle_cycle();
        check("rst_mid_req", 32'(req_a), 32'd0);
        check("rst_mid_count", 32'(sc_a), 32'd0);

        // Saturation of the narrow counter.
        do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_count4", 32'(sc_a), 32'd15);
        check("sat_count32", sc_b, 32'd20);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
